ground_contact_scanner: RTL and testbench

//  Consumer of the world-map platform table. On request, scans the N_ENTRIES packed ground

---
 rtl/world_pkg.sv | 29 ++
 rtl/ground_entry_hit.sv | 37 +++
 rtl/ground_contact_scanner.sv | 139 +++++++++++++
 tb/tb_ground_contact_scanner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/world_pkg.sv
// rtl/world_pkg.sv - platform table types shared by the map side and the ground contact scanner
package world_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int L_W      = 10;
  localparam int PW_W     = 6;
  localparam int N_GROUND = 16;
  localparam int ENTRY_W  = L_W + Y_W + X_W;

  // Bit-identical to one 29-bit table word: [9:0] x_start, [18:10] y_loc, [28:19] length
  typedef struct packed {
    logic [L_W-1:0] length;
    logic [Y_W-1:0] y_loc;
    logic [X_W-1:0] x_start;
  } ground_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  // Lowest feet row still accepted for a surface; clamps at row 0 instead of wrapping
  function automatic logic [Y_W-1:0] snap_floor(input logic [Y_W-1:0] y, input logic [Y_W-1:0] tol);
    return (y >= tol) ? (y - tol) : '0;
  endfunction

endpackage

// File: rtl/ground_entry_hit.sv
// rtl/ground_entry_hit.sv - combinational contact test of one platform entry against the latched player box
module ground_entry_hit
  import world_pkg::*;
#(
  parameter int unsigned TOL = 0
) (
  input  logic [ENTRY_W-1:0] i_entry,
  input  logic [X_W-1:0]     i_px,
  input  logic [Y_W-1:0]     i_py,
  input  logic [PW_W-1:0]    i_pw,
  output logic               o_hit
);

  localparam logic [Y_W-1:0] TOL_Y = Y_W'(TOL);

  ground_entry_t  w_e;
  logic [X_W:0]   w_p_end;
  logic [X_W:0]   w_e_end;
  logic [Y_W-1:0] w_y_lo;
  logic           w_x_hit;
  logic           w_y_hit;

  assign w_e = ground_entry_t'(i_entry);

  // Right edges carry one extra bit so x + width never wraps past 1023
  assign w_p_end = {1'b0, i_px} + {{(X_W + 1 - PW_W){1'b0}}, i_pw};
  assign w_e_end = {1'b0, w_e.x_start} + {1'b0, w_e.length};

  assign w_x_hit = (w_p_end > {1'b0, w_e.x_start}) && ({1'b0, i_px} < w_e_end);

  // A zero tolerance collapses the window to exact equality with the surface row
  assign w_y_lo  = snap_floor(w_e.y_loc, TOL_Y);
  assign w_y_hit = (i_py >= w_y_lo) && (i_py <= w_e.y_loc);

  assign o_hit = (w_e.length != '0) && (i_pw != '0) && w_x_hit && w_y_hit;

endmodule

// File: rtl/ground_contact_scanner.sv
// rtl/ground_contact_scanner.sv - one-entry-per-clock scan of the platform table for player ground contact
// Optional feature macro: GROUND_SNAP_EN (accept feet up to SNAP_TOL rows above a surface)
module ground_contact_scanner
  import world_pkg::*;
#(
  parameter int N_ENTRIES = N_GROUND,
  parameter int SNAP_TOL  = 4
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [ENTRY_W*N_ENTRIES-1:0]   info_ground,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [X_W-1:0]                 player_x,
  input  logic [Y_W-1:0]                 player_y,
  input  logic [PW_W-1:0]                player_w,
  output logic                           res_valid,
  output logic                           on_ground,
  output logic [Y_W-1:0]                 ground_y,
  output logic [$clog2(N_ENTRIES)-1:0]   ground_idx
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

`ifdef GROUND_SNAP_EN
  localparam int unsigned HIT_TOL = SNAP_TOL;
`else
  localparam int unsigned HIT_TOL = SNAP_TOL - SNAP_TOL;
`endif

  scan_state_t         r_state;
  scan_state_t         w_next;
  logic [IDX_W-1:0]    r_idx;
  logic [X_W-1:0]      r_px;
  logic [Y_W-1:0]      r_py;
  logic [PW_W-1:0]     r_pw;
  logic                r_best_hit;
  logic [Y_W-1:0]      r_best_y;
  logic [IDX_W-1:0]    r_best_idx;
  logic                r_res_valid;
  logic                r_on_ground;
  logic [Y_W-1:0]      r_ground_y;
  logic [IDX_W-1:0]    r_ground_idx;

  logic [ENTRY_W-1:0]  w_table [N_ENTRIES];
  ground_entry_t       w_cur;
  logic                w_hit;
  logic                w_accept;
  logic                w_better;

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_unpack
    assign w_table[g] = info_ground[g*ENTRY_W +: ENTRY_W];
  end

  // Table is sampled live: the entry under the scan index is whatever the map drives this cycle
  assign w_cur = ground_entry_t'(w_table[r_idx]);

  ground_entry_hit #(
    .TOL (HIT_TOL)
  ) u_hit (
    .i_entry (w_cur),
    .i_px    (r_px),
    .i_py    (r_py),
    .i_pw    (r_pw),
    .o_hit   (w_hit)
  );

  assign w_accept = req_valid && (r_state == ST_IDLE);

  // Strictly-less keeps the first-seen (lowest index) platform on equal heights
  assign w_better = w_hit && (!r_best_hit || (w_cur.y_loc < r_best_y));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_SCAN;
      ST_SCAN: if (r_idx == LAST_IDX) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_idx        <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_pw         <= '0;
      r_best_hit   <= 1'b0;
      r_best_y     <= '0;
      r_best_idx   <= '0;
      r_res_valid  <= 1'b0;
      r_on_ground  <= 1'b0;
      r_ground_y   <= '0;
      r_ground_idx <= '0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_accept) begin
        r_px       <= player_x;
        r_py       <= player_y;
        r_pw       <= player_w;
        r_idx      <= '0;
        r_best_hit <= 1'b0;
        r_best_y   <= '0;
        r_best_idx <= '0;
      end
      if (r_state == ST_SCAN) begin
        r_idx <= r_idx + 1'b1;
        if (w_better) begin
          r_best_hit <= 1'b1;
          r_best_y   <= w_cur.y_loc;
          r_best_idx <= r_idx;
        end
      end
      if (r_state == ST_DONE) begin
        r_res_valid  <= 1'b1;
        r_on_ground  <= r_best_hit;
        r_ground_y   <= r_best_y;
        r_ground_idx <= r_best_idx;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign res_valid  = r_res_valid;
  assign on_ground  = r_on_ground;
  assign ground_y   = r_ground_y;
  assign ground_idx = r_ground_idx;

endmodule

// File: tb/tb_ground_contact_scanner.sv
// tb/tb_ground_contact_scanner.sv - scoreboard bench for ground_contact_scanner (honours GROUND_SNAP_EN)
module tb_ground_contact_scanner;

  localparam int N = 16;
`ifdef GROUND_SNAP_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic [29*N-1:0] info_ground;
  logic          req_valid;
  logic          req_ready;
  logic [9:0]    player_x;
  logic [8:0]    player_y;
  logic [5:0]    player_w;
  logic          res_valid;
  logic          on_ground;
  logic [8:0]    ground_y;
  logic [3:0]    ground_idx;

  int tests_run = 0;
  int tests_failed = 0;

  logic [13:0] sb[$];

  ground_contact_scanner #(.N_ENTRIES(N), .SNAP_TOL(4)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .info_ground (info_ground),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .player_x    (player_x),
    .player_y    (player_y),
    .player_w    (player_w),
    .res_valid   (res_valid),
    .on_ground   (on_ground),
    .ground_y    (ground_y),
    .ground_idx  (ground_idx)
  );

  always #5 Clk = ~Clk;

  function automatic logic [13:0] exp_word(input bit on, input int y, input int idx);
    return {on, 9'(y), 4'(idx)};
  endfunction

  task automatic set_entry(input int i, input int x, input int y, input int len);
    info_ground[i*29 +: 29] = {10'(len), 9'(y), 10'(x)};
  endtask

  // Drive one request, scramble the player inputs after accept, wait for the result pulse
  task automatic issue(input int px, input int py, input int pw, output int lat, output bit got);
    @(negedge Clk);
    player_x = 10'(px); player_y = 9'(py); player_w = 6'(pw);
    req_valid = 1'b1;
    @(posedge Clk);
    #1;
    req_valid = 1'b0;
    player_x = 10'($urandom); player_y = 9'($urandom); player_w = 6'($urandom);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
      if (res_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; req_valid = 1'b0;
    player_x = '0; player_y = '0; player_w = '0;
    repeat (2) @(posedge Clk);
    #1;
    tests_run++;
    if ({req_ready, res_valid, on_ground, ground_y, ground_idx} !== {1'b1, 1'b0, 1'b0, 9'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL reset: rdy=%0b rv=%0b on=%0b y=%0d idx=%0d required 1 0 0 0 0",
               req_ready, res_valid, on_ground, ground_y, ground_idx);
    end
    @(negedge Clk); Reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat; bit got; logic [13:0] e;
    sb.push_back(exp_word(1, 200, 2));
    issue(100, 200, 32, lat, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || lat != 17) begin
      tests_failed++;
      $display("FAIL basic_latency: got=%0b cycles=%0d required 17", got, lat);
    end
    tests_run++;
    if ({on_ground, ground_y, ground_idx} !== e) begin
      tests_failed++;
      $display("FAIL basic_result: %h required %h", {on_ground, ground_y, ground_idx}, e);
    end
    @(posedge Clk); #1;
    tests_run++;
    if ({res_valid, on_ground, ground_y, ground_idx} !== {1'b0, e}) begin
      tests_failed++;
      $display("FAIL basic_hold: rv=%0b out=%h required rv=0 out=%h", res_valid, {on_ground, ground_y, ground_idx}, e);
    end
  endtask

  task automatic test_edges;
    int px[5] = '{274, 290, 54, 55, 100};
    int pw[5] = '{16, 16, 16, 16, 0};
    bit on[5] = '{1, 0, 0, 1, 0};
    int lat; bit got; logic [13:0] e;
    for (int k = 0; k < 5; k++) begin
      sb.push_back(exp_word(on[k], on[k] ? 200 : 0, on[k] ? 2 : 0));
      issue(px[k], 200, pw[k], lat, got);
      e = sb.pop_front();
      tests_run++;
      if (!got || {on_ground, ground_y, ground_idx} !== e) begin
        tests_failed++;
        $display("FAIL edges[%0d]: got=%0b out=%h required %h", k, got, {on_ground, ground_y, ground_idx}, e);
      end
    end
  endtask

  task automatic test_layers;
    int py[3]  = '{410, 310, 300};
    bit on[3]  = '{1, 1, 0};
    int idx[3] = '{0, 1, 0};
    int lat; bit got; logic [13:0] e;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(exp_word(on[k], on[k] ? py[k] : 0, idx[k]));
      issue(520, py[k], 16, lat, got);
      e = sb.pop_front();
      tests_run++;
      if (!got || {on_ground, ground_y, ground_idx} !== e) begin
        tests_failed++;
        $display("FAIL layers[%0d]: got=%0b out=%h required %h", k, got, {on_ground, ground_y, ground_idx}, e);
      end
    end
  endtask

  task automatic test_snap;
    int py[4] = '{198, 196, 195, 201};
    bit on[4];
    int lat; bit got; logic [13:0] e;
    on = '{SNAP, SNAP, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      sb.push_back(exp_word(on[k], on[k] ? 200 : 0, on[k] ? 2 : 0));
      issue(100, py[k], 32, lat, got);
      e = sb.pop_front();
      tests_run++;
      if (!got || {on_ground, ground_y, ground_idx} !== e) begin
        tests_failed++;
        $display("FAIL snap[%0d]: got=%0b out=%h required %h", k, got, {on_ground, ground_y, ground_idx}, e);
      end
    end
  endtask

  // Extra platforms: equal-height overlaps (4,5) and a slightly higher ledge (7)
  task automatic test_tie;
    int py[2] = '{200, 198};
    int lat; bit got; logic [13:0] e;
    set_entry(4, 60, 200, 50);
    set_entry(5, 100, 200, 10);
    set_entry(7, 95, 199, 10);
    sb.push_back(exp_word(1, 200, 2));
    sb.push_back(SNAP ? exp_word(1, 199, 7) : exp_word(0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      issue(100, py[k], 32, lat, got);
      e = sb.pop_front();
      tests_run++;
      if (!got || {on_ground, ground_y, ground_idx} !== e) begin
        tests_failed++;
        $display("FAIL tie[%0d]: got=%0b out=%h required %h", k, got, {on_ground, ground_y, ground_idx}, e);
      end
    end
    set_entry(4, 0, 0, 0);
    set_entry(5, 0, 0, 0);
    set_entry(7, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    int busy_bad = 0; int lat = 0; bit got = 1'b0; logic [13:0] e;
    @(negedge Clk);
    player_x = 10'd520; player_y = 9'd310; player_w = 6'd16;
    req_valid = 1'b1;
    @(posedge Clk);
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk); #1;
      if (req_ready !== 1'b0 || res_valid !== 1'b0) busy_bad++;
    end
    tests_run++;
    if (busy_bad != 0) begin
      tests_failed++;
      $display("FAIL midscan_busy: %0d bad cycles required 0", busy_bad);
    end
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    tests_run++;
    if ({req_ready, res_valid, on_ground, ground_y, ground_idx} !== {1'b1, 1'b0, 1'b0, 9'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL midscan_reset: rdy=%0b rv=%0b on=%0b y=%0d idx=%0d required 1 0 0 0 0",
               req_ready, res_valid, on_ground, ground_y, ground_idx);
    end
    sb.push_back(exp_word(1, 200, 2));
    @(negedge Clk);
    Reset = 1'b0; player_x = 10'd100; player_y = 9'd200; player_w = 6'd32;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    while (!got && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
      if (res_valid) got = 1'b1;
    end
    e = sb.pop_front();
    tests_run++;
    if (!got || lat != 17 || {on_ground, ground_y, ground_idx} !== e) begin
      tests_failed++;
      $display("FAIL after_reset: got=%0b cycles=%0d out=%h required 17 %h", got, lat, {on_ground, ground_y, ground_idx}, e);
    end
  endtask

  task automatic test_back_to_back;
    int acc = 0; int res = 0; int cyc = 0; logic [13:0] e;
    sb.push_back(exp_word(1, 410, 0));
    sb.push_back(exp_word(1, 200, 2));
    @(negedge Clk);
    player_x = 10'd520; player_y = 9'd410; player_w = 6'd16;
    req_valid = 1'b1;
    while (res < 2 && cyc < 80) begin
      if (req_valid && req_ready) acc++;
      @(posedge Clk); #1;
      cyc++;
      if (acc == 1) begin
        player_x = 10'd274; player_y = 9'd200; player_w = 6'd16;
      end else if (acc == 2) begin
        req_valid = 1'b0;
        player_x = 10'($urandom); player_y = 9'($urandom);
      end
      if (res_valid) begin
        e = sb.pop_front();
        tests_run++;
        if ({on_ground, ground_y, ground_idx} !== e) begin
          tests_failed++;
          $display("FAIL b2b[%0d]: out=%h required %h", res, {on_ground, ground_y, ground_idx}, e);
        end
        res++;
      end
      @(negedge Clk);
    end
    req_valid = 1'b0;
    tests_run++;
    if (res != 2 || acc != 2) begin
      tests_failed++;
      $display("FAIL b2b_count: results=%0d accepts=%0d required 2 2", res, acc);
    end
  endtask

  initial begin
    info_ground = '0;
    set_entry(0, 0, 410, 639);
    set_entry(1, 500, 310, 139);
    set_entry(2, 70, 200, 220);
    set_entry(3, 320, 250, 40);
    test_reset();
    test_basic();
    test_edges();
    test_layers();
    test_snap();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
